// File: rtl/game_pkg.sv
// Shared game constants and types: ammo FSM states, ammo width and default HUD colours.
package game_pkg;

    localparam int unsigned AMMO_W  = 4;
    localparam int unsigned COORD_W = 11;
    localparam int unsigned RGB_W   = 12;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        EMPTY     = 2'd1,
        RELOADING = 2'd2
    } ammo_state_t;

    localparam logic [RGB_W-1:0] DEF_SHELL_COLOR  = 12'hf_c_0;
    localparam logic [RGB_W-1:0] DEF_EMPTY_COLOR  = 12'h4_4_4;
    localparam logic [RGB_W-1:0] DEF_RELOAD_COLOR = 12'h0_8_f;

endpackage

// File: rtl/itf_vga.sv
// VGA pixel-stream bundle passed between drawing stages.
interface itf_vga;
    import game_pkg::*;

    logic [COORD_W-1:0] hcount;
    logic [COORD_W-1:0] vcount;
    logic               hblnk;
    logic               hsync;
    logic               vblnk;
    logic               vsync;
    logic [RGB_W-1:0]   rgb;

    modport in  (input  hcount, vcount, hblnk, hsync, vblnk, vsync, rgb);
    modport out (output hcount, vcount, hblnk, hsync, vblnk, vsync, rgb);
endinterface

// File: rtl/ammo_counter.sv
// Magazine bookkeeping: shot acceptance, timed reload and the empty flag.
module ammo_counter
    import game_pkg::*;
#(
    parameter int unsigned MAX_AMMO      = 6,
    parameter int unsigned RELOAD_CYCLES = 65_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger,
    input  logic              reload,
    output ammo_state_t       state,
    output logic [AMMO_W-1:0] ammo,
    output logic              no_ammo,
    output logic              shot_valid
);

    localparam int unsigned       CNT_W     = $clog2(RELOAD_CYCLES + 1);
    localparam logic [AMMO_W-1:0] FULL      = AMMO_W'(MAX_AMMO);
    localparam logic [CNT_W-1:0]  CNT_START = CNT_W'(RELOAD_CYCLES - 1);

    logic [CNT_W-1:0] reload_cnt;

    // Trigger has priority over reload in READY; EMPTY guards against underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= READY;
            ammo       <= FULL;
            reload_cnt <= '0;
            no_ammo    <= 1'b0;
            shot_valid <= 1'b0;
        end else begin
            shot_valid <= 1'b0;
            case (state)
                READY: begin
                    if (trigger) begin
                        ammo       <= ammo - AMMO_W'(1);
                        shot_valid <= 1'b1;
                        if (ammo == AMMO_W'(1)) begin
                            state   <= EMPTY;
                            no_ammo <= 1'b1;
                        end
                    end else if (reload && (ammo != FULL)) begin
                        state      <= RELOADING;
                        reload_cnt <= CNT_START;
                    end
                end
                EMPTY: begin
                    if (reload) begin
                        state      <= RELOADING;
                        reload_cnt <= CNT_START;
                        no_ammo    <= 1'b0;
                    end
                end
                RELOADING: begin
                    if (reload_cnt == '0) begin
                        ammo  <= FULL;
                        state <= READY;
                    end else begin
                        reload_cnt <= reload_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state   <= READY;
                    no_ammo <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/draw_ammo_bar.sv
// HUD stage: ammo bookkeeping plus a frame-stable row of shell icons over the VGA stream.
module draw_ammo_bar
    import game_pkg::*;
#(
    parameter int unsigned      MAX_AMMO      = 6,
    parameter int unsigned      RELOAD_CYCLES = 65_000_000,
    parameter int unsigned      BAR_X         = 900,
    parameter int unsigned      BAR_Y         = 720,
    parameter int unsigned      SHELL_W       = 12,
    parameter int unsigned      SHELL_H       = 24,
    parameter int unsigned      SHELL_GAP     = 6,
    parameter logic [RGB_W-1:0] SHELL_COLOR   = DEF_SHELL_COLOR,
    parameter logic [RGB_W-1:0] EMPTY_COLOR   = DEF_EMPTY_COLOR,
    parameter logic [RGB_W-1:0] RELOAD_COLOR  = DEF_RELOAD_COLOR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger,
    input  logic              reload,
    itf_vga.in                in,
    itf_vga.out               out,
    output logic              no_ammo,
    output logic              shot_valid,
    output logic [AMMO_W-1:0] ammo
);

    localparam int unsigned PITCH = SHELL_W + SHELL_GAP;

    ammo_state_t       state;
    logic [AMMO_W-1:0] disp_ammo;
    logic              disp_reloading;
    logic [11:0]       hx;
    logic [11:0]       vy;
    logic              in_row;
    logic              hit;
    logic [AMMO_W-1:0] hit_idx;
    logic [RGB_W-1:0]  rgb_nxt;

    ammo_counter #(
        .MAX_AMMO      (MAX_AMMO),
        .RELOAD_CYCLES (RELOAD_CYCLES)
    ) u_ammo_counter (
        .clk        (clk),
        .rst        (rst),
        .trigger    (trigger),
        .reload     (reload),
        .state      (state),
        .ammo       (ammo),
        .no_ammo    (no_ammo),
        .shot_valid (shot_valid)
    );

    // Latch what to draw at the first pixel so the bar never tears mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_ammo      <= AMMO_W'(MAX_AMMO);
            disp_reloading <= 1'b0;
        end else if ((in.hcount == '0) && (in.vcount == '0)) begin
            disp_ammo      <= ammo;
            disp_reloading <= (state == RELOADING);
        end
    end

    // 12-bit coordinates keep shell bounds from wrapping near the right edge.
    assign hx     = {1'b0, in.hcount};
    assign vy     = {1'b0, in.vcount};
    assign in_row = (vy >= 12'(BAR_Y)) && (vy < 12'(BAR_Y + SHELL_H));

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < MAX_AMMO; i++) begin
            if ((hx >= 12'(BAR_X + i * PITCH)) && (hx < 12'(BAR_X + i * PITCH + SHELL_W))) begin
                hit     = in_row;
                hit_idx = AMMO_W'(i);
            end
        end
    end

    always_comb begin
        rgb_nxt = in.rgb;
        if (in.hblnk || in.vblnk) begin
            rgb_nxt = '0;
        end else if (hit) begin
            if (disp_reloading) begin
                rgb_nxt = RELOAD_COLOR;
            end else if (hit_idx < disp_ammo) begin
                rgb_nxt = SHELL_COLOR;
            end else begin
                rgb_nxt = EMPTY_COLOR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hblnk  <= 1'b0;
            out.hsync  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.vsync  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.hcount <= in.hcount;
            out.vcount <= in.vcount;
            out.hblnk  <= in.hblnk;
            out.hsync  <= in.hsync;
            out.vblnk  <= in.vblnk;
            out.vsync  <= in.vsync;
            out.rgb    <= rgb_nxt;
        end
    end

endmodule

// File: tb/tb_draw_ammo_bar.sv
// Scoreboard bench for draw_ammo_bar with a 3-shell magazine and a 10-cycle reload.
module tb_draw_ammo_bar;

    localparam int MAX_AMMO = 3;
    localparam int RELOAD_C = 10;
    localparam int BX       = 900;
    localparam int BY       = 720;

    typedef struct {
        logic [3:0]  ammo;
        logic        na;
        logic        sv;
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hb;
        logic        hs;
        logic        vb;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trigger = 1'b0;
    logic       reload = 1'b0;
    logic       no_ammo;
    logic       shot_valid;
    logic [3:0] ammo;

    itf_vga vin();
    itf_vga vout();

    draw_ammo_bar #(
        .MAX_AMMO      (MAX_AMMO),
        .RELOAD_CYCLES (RELOAD_C)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trigger    (trigger),
        .reload     (reload),
        .in         (vin),
        .out        (vout),
        .no_ammo    (no_ammo),
        .shot_valid (shot_valid),
        .ammo       (ammo)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   tb_disp_ammo = MAX_AMMO;
    logic tb_disp_rel = 1'b0;
    int   cur_ammo = MAX_AMMO;
    logic cur_na = 1'b0;
    logic cur_rel = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Expected pixel colour from shell geometry, by division rather than per-shell compare.
    function automatic logic [11:0] exp_pix(input int hc, input int vc, input logic [11:0] rgb,
                                            input int da, input logic dr);
        int off;
        int idx;
        if (hc < BX || vc < BY || vc >= BY + 24) return rgb;
        off = hc - BX;
        idx = off / 18;
        if (idx >= MAX_AMMO || (off % 18) >= 12) return rgb;
        if (dr) return 12'h08f;
        return (idx < da) ? 12'hfc0 : 12'h444;
    endfunction

    task automatic step(input logic r, input logic t, input logic l,
                        input logic [10:0] hc, input logic [10:0] vc,
                        input logic hb, input logic vb, input logic [11:0] rgb,
                        input int e_ammo, input logic e_na, input logic e_sv, input logic e_rel);
        exp_t e;
        exp_t got;
        logic hs;
        logic vs;
        hs = 1'($urandom_range(1));
        vs = 1'($urandom_range(1));
        rst = r; trigger = t; reload = l;
        vin.hcount = hc; vin.vcount = vc; vin.hblnk = hb; vin.vblnk = vb;
        vin.hsync = hs; vin.vsync = vs; vin.rgb = rgb;
        if (r) begin
            e = '{ammo: 4'(MAX_AMMO), na: 1'b0, sv: 1'b0, hc: '0, vc: '0,
                  hb: 1'b0, hs: 1'b0, vb: 1'b0, vs: 1'b0, rgb: '0};
            tb_disp_ammo = MAX_AMMO; tb_disp_rel = 1'b0;
            cur_ammo = MAX_AMMO; cur_na = 1'b0; cur_rel = 1'b0;
        end else begin
            e.hc = hc; e.vc = vc; e.hb = hb; e.vb = vb; e.hs = hs; e.vs = vs;
            e.rgb = (hb || vb) ? 12'h000 : exp_pix(int'(hc), int'(vc), rgb, tb_disp_ammo, tb_disp_rel);
            if (hc == 11'd0 && vc == 11'd0) begin
                tb_disp_ammo = cur_ammo;
                tb_disp_rel  = cur_rel;
            end
            e.ammo = 4'(e_ammo); e.na = e_na; e.sv = e_sv;
            cur_ammo = e_ammo; cur_na = e_na; cur_rel = e_rel;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            chk("ammo",       32'(ammo),        32'(got.ammo));
            chk("no_ammo",    32'(no_ammo),     32'(got.na));
            chk("shot_valid", 32'(shot_valid),  32'(got.sv));
            chk("hcount",     32'(vout.hcount), 32'(got.hc));
            chk("vcount",     32'(vout.vcount), 32'(got.vc));
            chk("hblnk",      32'(vout.hblnk),  32'(got.hb));
            chk("hsync",      32'(vout.hsync),  32'(got.hs));
            chk("vblnk",      32'(vout.vblnk),  32'(got.vb));
            chk("vsync",      32'(vout.vsync),  32'(got.vs));
            chk("rgb",        32'(vout.rgb),    32'(got.rgb));
        end
    endtask

    // Background pixel away from the bar and the frame origin.
    task automatic bg(input logic t, input logic l, input int e_ammo,
                      input logic e_na, input logic e_sv, input logic e_rel);
        step(1'b0, t, l, 11'($urandom_range(799, 1)), 11'($urandom_range(699, 1)),
             1'b0, 1'b0, 12'($urandom), e_ammo, e_na, e_sv, e_rel);
    endtask

    // Pixel probe with no control activity; counter outputs hold.
    task automatic pix(input int hc, input int vc, input logic hb);
        step(1'b0, 1'b0, 1'b0, 11'(hc), 11'(vc), hb, 1'b0, 12'($urandom),
             cur_ammo, cur_na, 1'b0, cur_rel);
    endtask

    initial begin
        // Reset
        step(1'b1, 0, 0, 11'd5, 11'd5, 0, 0, 12'h123, MAX_AMMO, 0, 0, 0);
        step(1'b1, 0, 0, 11'd7, 11'd9, 1, 0, 12'h321, MAX_AMMO, 0, 0, 0);
        bg(0, 0, 3, 0, 0, 0);

        // Three shots empty the magazine; a fourth is ignored
        bg(1, 0, 2, 0, 1, 0);
        bg(1, 0, 1, 0, 1, 0);
        bg(1, 0, 0, 1, 1, 0);
        bg(1, 0, 0, 1, 0, 0);
        bg(0, 0, 0, 1, 0, 0);

        // Reload from empty; triggers and reloads ignored until refilled
        bg(0, 1, 0, 0, 0, 1);
        for (int k = 1; k < RELOAD_C; k++) bg(1'(k % 2), 1'(k == 4), 0, 0, 0, 1);
        bg(0, 0, 3, 0, 0, 0);

        // Trigger beats reload when both arrive together
        bg(1, 0, 2, 0, 1, 0);
        bg(1, 1, 1, 0, 1, 0);

        // Frame-stable drawing: ammo=1 latched, shot mid-frame shows next frame
        pix(0, 0, 0);
        pix(BX, BY, 0);
        pix(BX + 18, BY, 0);
        pix(BX + 13, BY, 0);
        pix(BX + 36, BY + 23, 0);
        pix(BX + 11, BY + 24, 0);
        bg(1, 0, 0, 1, 1, 0);
        pix(BX, BY + 10, 0);
        pix(BX, BY, 1);
        pix(0, 0, 0);
        pix(BX, BY, 0);

        // Reload drawn in reload colour once latched
        bg(0, 1, 0, 0, 0, 1);
        pix(0, 0, 0);
        pix(BX, BY, 0);
        pix(BX + 20, BY + 5, 0);
        for (int k = 4; k < RELOAD_C; k++) bg(1, 0, 0, 0, 0, 1);
        bg(0, 0, 3, 0, 0, 0);

        // Reload at full magazine does nothing
        bg(0, 1, 3, 0, 0, 0);
        bg(1, 0, 2, 0, 1, 0);

        // Reset in the middle of a reload
        bg(0, 1, 2, 0, 0, 1);
        for (int k = 0; k < 5; k++) bg(0, 0, 2, 0, 0, 1);
        step(1'b1, 0, 0, 11'd100, 11'd200, 0, 1, 12'habc, MAX_AMMO, 0, 0, 0);
        bg(0, 0, 3, 0, 0, 0);
        bg(1, 0, 2, 0, 1, 0);

        // Random passthrough with blanking
        for (int k = 0; k < 24; k++) begin
            step(1'b0, 0, 0, 11'($urandom_range(1023, 1)), 11'($urandom_range(700, 1)),
                 1'($urandom_range(1)), 1'($urandom_range(3) == 0), 12'($urandom),
                 cur_ammo, cur_na, 1'b0, cur_rel);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
